// File: rtl/calc1_port_responder_if.sv
// Command/response bundle between a calc1 requester (master) and the responder (slave).
// dbg_state mirrors the responder FSM state so checkers can bind to it directly.
interface calc1_port_responder_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        req_cmd_in;
  logic [DATA_W-1:0] req_data_in;
  logic              busy;
  logic [1:0]        out_resp;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        dbg_state;

  // Handshake: the command is taken only while busy is low; the operand pair is
  // presented on two consecutive cycles and the response is a one-cycle pulse with
  // out_resp != 0. There is no ready/backpressure: commands seen while busy are dropped.
  modport master (
    output req_cmd_in, req_data_in,
    input  busy, out_resp, out_data, dbg_state
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output busy, out_resp, out_data, dbg_state
  );
endinterface

// File: rtl/calc1_port_responder.sv
// calc1 responder: takes cmd+op1, then op2, waits EXEC_LAT cycles, returns a one-cycle
// registered response (add/sub/shl/shr on unsigned operands).
module calc1_port_responder #(
  parameter int DATA_W   = 32,
  parameter int EXEC_LAT = 3
) (
  input  logic                   c_clk,
  input  logic                   reset_n,
  calc1_port_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP2  = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cmd;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_resp;
  logic [DATA_W-1:0] r_data;

  logic              w_resp_load;
  logic [1:0]        w_resp_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic [DATA_W:0]   w_sum;

  // State register
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.req_cmd_in != 4'd0) w_state_nxt = S_OP2;
      S_OP2:  w_state_nxt = S_EXEC;
      S_EXEC: if (r_cnt == '0) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and execution counter
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_cmd_in != 4'd0) begin
            r_cmd <= bus.req_cmd_in;
            r_op1 <= bus.req_data_in;
          end
        end
        S_OP2: begin
          r_op2 <= bus.req_data_in;
          r_cnt <= CNT_W'(EXEC_LAT - 1);
        end
        S_EXEC: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output logic: result is formed on the last EXEC cycle and registered into RESP
  always_comb begin
    w_sum       = {1'b0, r_op1} + {1'b0, r_op2};
    w_resp_load = (r_state == S_EXEC) && (r_cnt == '0);
    w_resp_nxt  = 2'd2;
    w_data_nxt  = '0;
    case (r_cmd)
      CMD_ADD: begin
        if (!w_sum[DATA_W]) begin
          w_resp_nxt = 2'd1;
          w_data_nxt = w_sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (r_op2 <= r_op1) begin
          w_resp_nxt = 2'd1;
          w_data_nxt = r_op1 - r_op2;
        end
      end
      CMD_SHL: begin
        w_resp_nxt = 2'd1;
        w_data_nxt = r_op1 << r_op2[4:0];
      end
      CMD_SHR: begin
        w_resp_nxt = 2'd1;
        w_data_nxt = r_op1 >> r_op2[4:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp <= 2'd0;
      r_data <= '0;
    end else if (w_resp_load) begin
      r_resp <= w_resp_nxt;
      r_data <= w_data_nxt;
    end else begin
      r_resp <= 2'd0;
      r_data <= '0;
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_resp  = r_resp;
  assign bus.out_data  = r_data;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_calc1_port_responder.sv
// Bench for calc1_port_responder: directed protocol cases plus randomized traffic,
// all checked each cycle against a transaction-level model of the responder.
module tb_calc1_port_responder;

  localparam int DATA_W   = 32;
  localparam int EXEC_LAT = 3;
  localparam int RESP_OFS = 2 + EXEC_LAT;

  logic c_clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  calc1_port_responder_if #(.DATA_W(DATA_W)) bus_if ();

  calc1_port_responder #(.DATA_W(DATA_W), .EXEC_LAT(EXEC_LAT)) dut (
    .c_clk   (c_clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  initial cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  // ---------------- model ----------------
  // Expected-response entries: {window, resp, data}
  logic [65:0] exp_q[$];
  int          last_resp_win = -100;
  int          busy_lo = 1;
  int          busy_hi = 0;
  bit          pend = 1'b0;
  logic [3:0]  pend_cmd;
  logic [31:0] pend_op1;
  int          pend_win;

  function automatic logic [33:0] model_calc(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned s;
    case (c)
      4'd1: begin
        s = longint'(a) + longint'(b);
        if (s > 64'h0000_0000_FFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, s[31:0]};
      end
      4'd2: begin
        if (b > a) return {2'd2, 32'd0};
        return {2'd1, a - b};
      end
      4'd5: return {2'd1, a << (b % 32)};
      4'd6: return {2'd1, a >> (b % 32)};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  task automatic model_observe(input logic [3:0] cmd, input logic [31:0] data);
    logic [33:0] r;
    if (!reset_n) return;
    if (pend) begin
      r = model_calc(pend_cmd, pend_op1, data);
      exp_q.push_back({32'(pend_win + RESP_OFS), r});
      pend = 1'b0;
    end else if (cmd != 4'd0 && cyc > last_resp_win) begin
      pend          = 1'b1;
      pend_cmd      = cmd;
      pend_op1      = data;
      pend_win      = cyc;
      last_resp_win = cyc + RESP_OFS;
      busy_lo       = cyc + 1;
      busy_hi       = cyc + RESP_OFS;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend          = 1'b0;
    last_resp_win = -100;
    busy_lo       = 1;
    busy_hi       = 0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (window %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge c_clk) begin
    logic [1:0]  e_resp;
    logic [31:0] e_data;
    logic        e_busy;
    e_resp = 2'd0;
    e_data = 32'd0;
    e_busy = 1'b0;
    if (reset_n) begin
      if (exp_q.size() > 0 && int'(exp_q[0][65:34]) == cyc) begin
        e_resp = exp_q[0][33:32];
        e_data = exp_q[0][31:0];
        void'(exp_q.pop_front());
      end
      e_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    end
    check("cyc_resp", 64'(bus_if.out_resp), 64'(e_resp));
    check("cyc_data", 64'(bus_if.out_data), 64'(e_data));
    check("cyc_busy", 64'(bus_if.busy), 64'(e_busy));
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] cmd, input logic [31:0] data);
    @(negedge c_clk);
    bus_if.req_cmd_in  = cmd;
    bus_if.req_data_in = data;
    model_observe(cmd, data);
  endtask

  // One full transaction with a hand-computed literal expectation at the response window
  task automatic run_txn(input string name, input logic [3:0] cmd, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [1:0] er, input logic [31:0] ed);
    drive(cmd, op1);
    drive(4'($urandom_range(0, 15)), op2);
    repeat (EXEC_LAT + 1) drive(4'd0, $urandom);
    check({name, "_resp"}, 64'(bus_if.out_resp), 64'(er));
    check({name, "_data"}, 64'(bus_if.out_data), 64'(ed));
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 40));
      2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: return 32'd1 << $urandom_range(0, 31);
    endcase
  endfunction

  function automatic logic [3:0] rand_cmd();
    logic [3:0] tbl[4];
    tbl = '{4'd1, 4'd2, 4'd5, 4'd6};
    case ($urandom_range(0, 9))
      0, 1, 2: return 4'd0;
      3:       return 4'($urandom_range(3, 15));
      default: return tbl[$urandom_range(0, 3)];
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    n_checks = 0;
    n_errors = 0;
    reset_n            = 1'b0;
    bus_if.req_cmd_in  = 4'd0;
    bus_if.req_data_in = 32'd0;

    // Literal pins on the model itself
    check("model_add_ovf", 64'(model_calc(4'd1, 32'hFFFF_FFFF, 32'd1)), {30'd0, 2'd2, 32'd0});
    check("model_sub_eq",  64'(model_calc(4'd2, 32'd6, 32'd6)),         {30'd0, 2'd1, 32'd0});
    check("model_shl_amt", 64'(model_calc(4'd5, 32'd1, 32'h21)),        {30'd0, 2'd1, 32'd2});
    check("model_inval",   64'(model_calc(4'd9, 32'd3, 32'd4)),         {30'd0, 2'd2, 32'd0});

    repeat (3) @(negedge c_clk);
    check("rst_resp",  64'(bus_if.out_resp),  64'd0);
    check("rst_data",  64'(bus_if.out_data),  64'd0);
    check("rst_busy",  64'(bus_if.busy),      64'd0);
    check("rst_state", 64'(bus_if.dbg_state), 64'd0);
    @(negedge c_clk);
    reset_n = 1'b1;
    drive(4'd0, 32'd0);

    for (int k = 0; k < 32; k++) begin
      v = 32'd1 << k;
      run_txn("walk_add", 4'd1, v, 32'd0, 2'd1, v);
    end

    run_txn("add_ovf",  4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 32'd0);
    run_txn("add_max",  4'd1, 32'hFFFF_FFFE, 32'd1, 2'd1, 32'hFFFF_FFFF);
    run_txn("sub_unf",  4'd2, 32'd5,  32'd6, 2'd2, 32'd0);
    run_txn("sub_eq",   4'd2, 32'd6,  32'd6, 2'd1, 32'd0);
    run_txn("sub_pos",  4'd2, 32'd10, 32'd3, 2'd1, 32'd7);
    run_txn("shl_wrap", 4'd5, 32'd1, 32'h21, 2'd1, 32'd2);
    run_txn("shr_31",   4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'd1);
    run_txn("invalid",  4'd3, 32'd12, 32'd4, 2'd2, 32'd0);

    // Command while busy is dropped; response belongs to the first command only
    drive(4'd1, 32'd2);
    drive(4'd0, 32'd3);
    drive(4'd1, 32'd7);
    drive(4'd0, 32'd7);
    drive(4'd1, 32'd9);
    drive(4'd1, 32'd9);
    check("drop_resp", 64'(bus_if.out_resp), 64'd1);
    check("drop_data", 64'(bus_if.out_data), 64'd5);
    repeat (RESP_OFS + 2) drive(4'd0, 32'd0);

    // Reset during EXEC of add 1+1
    drive(4'd1, 32'd1);
    drive(4'd0, 32'd1);
    drive(4'd0, 32'd0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_busy",  64'(bus_if.busy),      64'd0);
    check("midrst_resp",  64'(bus_if.out_resp),  64'd0);
    check("midrst_data",  64'(bus_if.out_data),  64'd0);
    check("midrst_state", 64'(bus_if.dbg_state), 64'd0);
    drive(4'd0, 32'd0);
    drive(4'd0, 32'd0);
    @(negedge c_clk);
    reset_n = 1'b1;
    repeat (RESP_OFS + 2) drive(4'd0, 32'd0);
    run_txn("post_rst", 4'd1, 32'd4, 32'd4, 2'd1, 32'd8);

    // Randomized traffic, including commands landing while busy or in the response cycle
    for (int i = 0; i < 600; i++) drive(rand_cmd(), rand_data());
    repeat (RESP_OFS + 3) drive(4'd0, 32'd0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
